// File: rtl/pcd_frame_builder.sv
// AXI-Stream command-frame packer for the PCD transmitter, with trigger/busy handshake.
// Define PCD_FRAME_CRC_EN to append ISO 14443-3 CRC_A; otherwise bytes pass through raw.
module pcd_frame_builder #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_FRAME_BYTES        = 5
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic [8*MAX_FRAME_BYTES-1:0]          pcd_data_out,
    output logic [2:0]                            pcd_num_bytes_out,
    output logic                                  pcd_trigger_out,
    input  logic                                  pcd_busy_in,
    output logic                                  frame_err_out,
    output logic [15:0]                           frames_sent_out
);

    localparam int DW = 8 * MAX_FRAME_BYTES;
    localparam int KW = $clog2(MAX_FRAME_BYTES + 2);
`ifdef PCD_FRAME_CRC_EN
    localparam int PLIM = MAX_FRAME_BYTES - 2;
`else
    localparam int PLIM = MAX_FRAME_BYTES;
`endif
    localparam logic [KW-1:0] K_LIM = KW'(PLIM);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_DISCARD = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] k_q, k_d;
    logic [2:0]    nb_q, nb_d;
    logic          trigger_q, trigger_d;
    logic          err_q, err_d;
    logic          tready_q, tready_d;
    logic [15:0]   frames_q, frames_d;
    logic          busy_meta_q, busy_sync_q;
    logic          beat, has_byte;
    logic          unused_bits;

`ifdef PCD_FRAME_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_pend_q, crc_pend_d;

    function automatic logic [15:0] crc_a_next(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign beat        = s00_axis_tvalid & tready_q;
    assign has_byte    = beat & s00_axis_tstrb[0];
    assign unused_bits = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:8],
                           s00_axis_tstrb[(C_S00_AXIS_TDATA_WIDTH/8)-1:1]};

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        k_d       = k_q;
        nb_d      = nb_q;
        trigger_d = trigger_q;
        err_d     = err_q;
        frames_d  = frames_q;
`ifdef PCD_FRAME_CRC_EN
        crc_d      = crc_q;
        crc_pend_d = crc_pend_q;
`endif
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (beat) begin
                    if (has_byte && (k_q == K_LIM) && !s00_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end else begin
                        if (has_byte) begin
                            for (int unsigned i = 0; i < MAX_FRAME_BYTES; i++) begin
                                if (k_q == KW'(i)) data_d[8*i +: 8] = s00_axis_tdata[7:0];
                            end
                            k_d = k_q + KW'(1);
`ifdef PCD_FRAME_CRC_EN
                            crc_d = crc_a_next(crc_q, s00_axis_tdata[7:0]);
`endif
                        end
                        if (s00_axis_tlast) begin
                            if (k_d == '0) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_ISSUE;
`ifdef PCD_FRAME_CRC_EN
                                crc_pend_d = 1'b1;
`else
                                nb_d = 3'(k_d);
`endif
                            end
                        end else begin
                            state_d = S_COLLECT;
                        end
                    end
                end
            end
            S_ISSUE: begin
`ifdef PCD_FRAME_CRC_EN
                // First ISSUE cycle only lays down the CRC bytes; the trigger follows a cycle later.
                if (crc_pend_q) begin
                    for (int unsigned i = 0; i < MAX_FRAME_BYTES; i++) begin
                        if (k_q == KW'(i))            data_d[8*i +: 8] = crc_q[7:0];
                        if ((k_q + KW'(1)) == KW'(i)) data_d[8*i +: 8] = crc_q[15:8];
                    end
                    nb_d       = 3'(k_q + KW'(2));
                    crc_pend_d = 1'b0;
                end else begin
                    trigger_d = 1'b1;
                    state_d   = S_WAIT_HI;
                end
`else
                trigger_d = 1'b1;
                state_d   = S_WAIT_HI;
`endif
            end
            S_WAIT_HI: begin
                if (busy_sync_q) begin
                    trigger_d = 1'b0;
                    state_d   = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!busy_sync_q) begin
                    frames_d = frames_q + 16'd1;
                    err_d    = 1'b0;
                    k_d      = '0;
                    data_d   = '0;
                    state_d  = S_IDLE;
`ifdef PCD_FRAME_CRC_EN
                    crc_d = 16'h6363;
`endif
                end
            end
            S_DISCARD: begin
                if (beat && s00_axis_tlast) begin
                    data_d  = '0;
                    k_d     = '0;
                    state_d = S_IDLE;
`ifdef PCD_FRAME_CRC_EN
                    crc_d = 16'h6363;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        tready_d = (state_d == S_IDLE) || (state_d == S_COLLECT) || (state_d == S_DISCARD);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            k_q         <= '0;
            nb_q        <= '0;
            trigger_q   <= 1'b0;
            err_q       <= 1'b0;
            tready_q    <= 1'b0;
            frames_q    <= '0;
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
`ifdef PCD_FRAME_CRC_EN
            crc_q      <= 16'h6363;
            crc_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            k_q         <= k_d;
            nb_q        <= nb_d;
            trigger_q   <= trigger_d;
            err_q       <= err_d;
            tready_q    <= tready_d;
            frames_q    <= frames_d;
            busy_meta_q <= pcd_busy_in;
            busy_sync_q <= busy_meta_q;
`ifdef PCD_FRAME_CRC_EN
            crc_q      <= crc_d;
            crc_pend_q <= crc_pend_d;
`endif
        end
    end

    assign s00_axis_tready   = tready_q;
    assign pcd_data_out      = data_q;
    assign pcd_num_bytes_out = nb_q;
    assign pcd_trigger_out   = trigger_q;
    assign frame_err_out     = err_q;
    assign frames_sent_out   = frames_q;

endmodule

// File: tb/tb_pcd_frame_builder.sv
// Directed scoreboard bench for pcd_frame_builder; honours PCD_FRAME_CRC_EN like the design.
module tb_pcd_frame_builder;

    localparam int W  = 32;
    localparam int MB = 5;
`ifdef PCD_FRAME_CRC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [8*MB-1:0] data;
        logic [2:0]      nb;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tvalid;
    logic            tready;
    logic [W-1:0]    tdata;
    logic [W/8-1:0]  tstrb;
    logic            tlast;
    logic [8*MB-1:0] pcd_data_out;
    logic [2:0]      pcd_num_bytes_out;
    logic            trigger;
    logic            busy;
    logic            frame_err;
    logic [15:0]     frames_sent;

    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;

    pcd_frame_builder #(
        .C_S00_AXIS_TDATA_WIDTH(W),
        .MAX_FRAME_BYTES(MB)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tready(tready),
        .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb),
        .s00_axis_tlast(tlast),
        .pcd_data_out(pcd_data_out),
        .pcd_num_bytes_out(pcd_num_bytes_out),
        .pcd_trigger_out(trigger),
        .pcd_busy_in(busy),
        .frame_err_out(frame_err),
        .frames_sent_out(frames_sent)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*MB-1:0] bytemask(input logic [2:0] nb);
        logic [8*MB-1:0] m = '0;
        for (int i = 0; i < MB; i++) if (i < int'(nb)) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference frame: payload bytes, plus CRC_A (low byte first) when enabled.
    function automatic exp_t model(input logic [63:0] b, input int n);
        exp_t r;
        logic [15:0] c;
        r.data = '0;
        for (int i = 0; i < n; i++) r.data[8*i +: 8] = b[8*i +: 8];
`ifdef PCD_FRAME_CRC_EN
        c = 16'h6363;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, b[8*i +: 8]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        r.data[8*n +: 8]     = c[7:0];
        r.data[8*n + 8 +: 8] = c[15:8];
        r.nb = 3'(n + 2);
`else
        r.nb = 3'(n);
`endif
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send_beat(input logic [7:0] d, input logic s, input logic l);
        int n = 0;
        tvalid = 1'b1;
        tdata  = {24'hC3C3C3, d};
        tstrb  = {3'b101, s};
        tlast  = l;
        while (tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tready_wait", {63'd0, tready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tstrb  = '0;
    endtask

    task automatic send_frame(input logic [63:0] b, input int n);
        for (int i = 0; i < n; i++) send_beat(b[8*i +: 8], 1'b1, i == n - 1);
    endtask

    task automatic expect_launch(output exp_t x);
        check("trig_at_accept", {63'd0, trigger}, 64'd0);
        check("tready_after_tlast", {63'd0, tready}, 64'd0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            check(i == LAT ? "trig_rise" : "trig_crc_cycle", {63'd0, trigger}, (i == LAT) ? 64'd1 : 64'd0);
        end
        check("sb_pending", {63'd0, sbq.size() > 0}, 64'd1);
        x = '{data: '0, nb: '0};
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            check("frame_data", 64'(pcd_data_out & bytemask(x.nb)), 64'(x.data));
            check("frame_nbytes", 64'(pcd_num_bytes_out), 64'(x.nb));
        end
    endtask

    task automatic complete_tx(input int hi, input int lo, input exp_t x);
        logic dropped = 1'b0;
        repeat (hi) begin
            @(negedge clk);
            if (trigger !== 1'b1) dropped = 1'b1;
        end
        check("trig_hold_pre_busy", {63'd0, dropped}, 64'd0);
        busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("trig_hold_sync", {63'd0, trigger}, 64'd1);
        @(negedge clk);
        check("trig_fall", {63'd0, trigger}, 64'd0);
        repeat (lo) @(negedge clk);
        check("data_stable", 64'(pcd_data_out & bytemask(x.nb)), 64'(x.data));
        check("nbytes_stable", 64'(pcd_num_bytes_out), 64'(x.nb));
        check("tready_wait_lo", {63'd0, tready}, 64'd0);
        busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("frames_before_sync", 64'(frames_sent), 64'(exp_frames));
        @(negedge clk);
        exp_frames++;
        check("frames_sent", 64'(frames_sent), 64'(exp_frames));
        check("tready_back", {63'd0, tready}, 64'd1);
    endtask

    task automatic no_trigger(input string tag);
        logic seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (trigger !== 1'b0) seen = 1'b1;
        end
        check(tag, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tstrb  = '0;
        tlast  = 1'b0;
        busy   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tready", {63'd0, tready}, 64'd0);
        check("rst_trigger", {63'd0, trigger}, 64'd0);
        check("rst_err", {63'd0, frame_err}, 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        check("rst_data", 64'(pcd_data_out), 64'd0);
        check("rst_nbytes", 64'(pcd_num_bytes_out), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("tready_idle", {63'd0, tready}, 64'd1);

`ifdef PCD_FRAME_CRC_EN
        sbq.push_back('{data: 40'h00_1EA0_0000, nb: 3'd4});
        send_frame(64'h0000, 2);
        expect_launch(e);
        complete_tx(3, 5, e);

        sbq.push_back('{data: 40'h00_CD57_0050, nb: 3'd4});
        send_frame(64'h0050, 2);
        expect_launch(e);
        complete_tx(40, 500, e);

        send_beat(8'h12, 1'b1, 1'b0);
        send_beat(8'h34, 1'b1, 1'b0);
        send_beat(8'h56, 1'b1, 1'b0);
        check("err_before_ovf", {63'd0, frame_err}, 64'd0);
        send_beat(8'h78, 1'b1, 1'b0);
`else
        sbq.push_back('{data: 40'h05_0403_0201, nb: 3'd5});
        send_frame(64'h05_0403_0201, 5);
        expect_launch(e);
        complete_tx(40, 500, e);

        for (int i = 1; i <= 5; i++) send_beat(8'(i), 1'b1, 1'b0);
        check("err_before_ovf", {63'd0, frame_err}, 64'd0);
        send_beat(8'h06, 1'b1, 1'b0);
`endif
        check("err_ovf", {63'd0, frame_err}, 64'd1);
        check("tready_discard", {63'd0, tready}, 64'd1);
        send_beat(8'h9A, 1'b1, 1'b1);
        no_trigger("no_trig_ovf");
        check("err_sticky", {63'd0, frame_err}, 64'd1);
        check("tready_after_discard", {63'd0, tready}, 64'd1);

`ifdef PCD_FRAME_CRC_EN
        sbq.push_back('{data: 40'h00_CF26_3412, nb: 3'd4});
        send_frame(64'h3412, 2);
`else
        sbq.push_back(model(64'hBBAA, 2));
        send_frame(64'hBBAA, 2);
`endif
        expect_launch(e);
        complete_tx(5, 8, e);
        check("err_cleared_ovf", {63'd0, frame_err}, 64'd0);

        send_beat(8'h55, 1'b0, 1'b1);
        check("err_empty", {63'd0, frame_err}, 64'd1);
        no_trigger("no_trig_empty");
        check("tready_after_empty", {63'd0, tready}, 64'd1);

        sbq.push_back(model(64'h2093, 2));
        send_beat(8'h93, 1'b1, 1'b0);
        send_beat(8'hFF, 1'b0, 1'b0);
        send_beat(8'h20, 1'b1, 1'b1);
        expect_launch(e);
        complete_tx(4, 6, e);
        check("err_cleared_empty", {63'd0, frame_err}, 64'd0);

        sbq.push_back(model(64'h26, 1));
        send_frame(64'h26, 1);
        expect_launch(e);
        busy = 1'b1;
        repeat (5) @(negedge clk);
        check("trig_low_wait_lo", {63'd0, trigger}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_trigger", {63'd0, trigger}, 64'd0);
        check("midrst_frames", 64'(frames_sent), 64'd0);
        check("midrst_tready", {63'd0, tready}, 64'd0);
        @(negedge clk);
        busy  = 1'b0;
        rst_n = 1'b1;
        exp_frames = 0;
        repeat (3) @(negedge clk);

        sbq.push_back(model(64'h0050, 2));
        send_frame(64'h0050, 2);
        expect_launch(e);
        complete_tx(6, 10, e);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
